// File: rtl/prog_mem_loader_pkg.sv
// Shared types for the program-memory loader: FSM state encoding and word geometry.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

    // Byte counter width; covers up to 4 bytes per word (IW <= 32).
    localparam int unsigned CNT_W = 2;

    function automatic int bytes_per_word(input int iw);
        return (iw + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// Fetch port and byte-serial load port of the program-memory loader.
interface prog_mem_loader_if #(
    parameter int IW = 12,
    parameter int AW = 8
);
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          ld_start;
    logic [AW-1:0] ld_last;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;

    modport master (
        output fetch_en, fetch_addr, ld_start, ld_last, ld_valid, ld_byte,
        input  instr, instr_valid, ld_ready, ld_busy, ld_done
    );

    modport slave (
        input  fetch_en, fetch_addr, ld_start, ld_last, ld_valid, ld_byte,
        output instr, instr_valid, ld_ready, ld_busy, ld_done
    );
endinterface

// File: rtl/prog_mem_loader_ram.sv
// Single-clock word RAM: one synchronous write port, one registered read port.
// The array itself has no reset so contents survive rst; only the read register clears.
module prog_ram #(
    parameter int IW = 12,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o,
    output logic          rvalid_o
);
    logic [IW-1:0] mem_q [2**AW];
    logic [IW-1:0] rdata_q;
    logic          rvalid_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Idle read cycles return zero rather than holding the previous word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re_i;
            rdata_q  <= re_i ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Program memory with a byte-serial little-endian loader and a latency-1 fetch port.
// Fetches are refused while a load session is active.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int IW = 12,
    parameter int AW = 8
) (
    input  logic                clk,
    input  logic                rst,
    prog_mem_loader_if.slave    bus
);
    localparam int BPW = bytes_per_word(IW);

    ld_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    last_q, last_d;
    logic [IW-1:0]    word_q, word_d;
    logic             we;
    logic             fetch_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            last_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        last_d  = last_q;
        word_d  = word_q;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.ld_start) begin
                    state_d = ST_RECV;
                    last_d  = bus.ld_last;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RECV: begin
                if (bus.ld_valid) begin
                    // Byte k lands in bits [8k+7:8k]; bits at or above IW never exist here.
                    for (int b = 0; b < IW; b++) begin
                        if (cnt_q == CNT_W'(b / 8)) begin
                            word_d[b] = bus.ld_byte[3'(b % 8)];
                        end
                    end
                    if (cnt_q == CNT_W'(BPW - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                we = 1'b1;
                if (addr_q == last_q) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_RECV;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ld_ready = (state_q == ST_RECV);
    assign bus.ld_busy  = (state_q != ST_IDLE);
    assign bus.ld_done  = (state_q == ST_DONE);
    assign fetch_acc    = bus.fetch_en && (state_q == ST_IDLE);

    prog_ram #(
        .IW (IW),
        .AW (AW)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we_i     (we),
        .waddr_i  (addr_q),
        .wdata_i  (word_q),
        .re_i     (fetch_acc),
        .raddr_i  (bus.fetch_addr),
        .rdata_o  (bus.instr),
        .rvalid_o (bus.instr_valid)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed and randomized load sessions checked against a word-array model.
module tb_prog_mem_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_mem_loader_if #(.IW(12), .AW(8)) bus ();
    prog_mem_loader_if #(.IW(12), .AW(2)) bus2 ();

    prog_mem_loader #(.IW(12), .AW(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    prog_mem_loader #(.IW(12), .AW(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt  = 0;
    int done_cnt2 = 0;
    logic [11:0] model [256];

    always @(negedge clk) begin
        if (bus.ld_done === 1'b1)  done_cnt++;
        if (bus2.ld_done === 1'b1) done_cnt2++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [7:0] last);
        bus.ld_start = 1'b1;
        bus.ld_last  = last;
        tick();
        bus.ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd, inout int tmo);
        int g;
        while (rnd && $urandom_range(0, 2) == 0) begin
            bus.ld_valid = 1'b0;
            bus.ld_byte  = 8'($urandom);
            tick();
        end
        bus.ld_valid = 1'b1;
        bus.ld_byte  = b;
        g = 0;
        while (bus.ld_ready !== 1'b1 && g < 40) begin
            tick();
            g++;
        end
        if (g >= 40) tmo++;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    // Returns ld_ready/ld_busy seen in the cycle after the final byte (the write cycle).
    task automatic send_word(input logic [11:0] w, input bit rnd, input bit junk, inout int tmo,
                             output logic rdy_w, output logic busy_w);
        logic [3:0] hi;
        hi = junk ? 4'($urandom) : 4'h0;
        send_byte(w[7:0], rnd, tmo);
        send_byte({hi, w[11:8]}, rnd, tmo);
        rdy_w  = bus.ld_ready;
        busy_w = bus.ld_busy;
    endtask

    task automatic do_fetch(input logic [7:0] a);
        bus.fetch_en   = 1'b1;
        bus.fetch_addr = a;
        tick();
        bus.fetch_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ld_start = 1'b1;
        repeat (3) tick();
        bus.ld_start = 1'b0;
        n_checks++;
        if ({bus.ld_ready, bus.ld_busy, bus.ld_done, bus.instr_valid} !== 4'b0000)
            $display("FAIL reset_flags got=%b exp=0000", {bus.ld_ready, bus.ld_busy, bus.ld_done, bus.instr_valid});
        else n_pass++;
        n_checks++;
        if (bus.instr !== 12'h000) $display("FAIL reset_instr got=%h exp=000", bus.instr);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.ld_busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", bus.ld_busy);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [11:0] w [3];
        logic rdy_w, busy_w;
        int tmo = 0;
        int d0 = done_cnt;
        w[0] = 12'h134; w[1] = 12'h678; w[2] = 12'hABC;
        start_session(8'd2);
        n_checks++;
        if ({bus.ld_busy, bus.ld_ready} !== 2'b11) $display("FAIL dir_start got=%b exp=11", {bus.ld_busy, bus.ld_ready});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            send_word(w[i], 1'b0, 1'b0, tmo, rdy_w, busy_w);
            n_checks++;
            if ({rdy_w, busy_w} !== 2'b01) $display("FAIL dir_write_cycle got=%b exp=01", {rdy_w, busy_w});
            else n_pass++;
            model[i] = w[i];
        end
        tick();
        n_checks++;
        if ({bus.ld_done, bus.ld_busy} !== 2'b11) $display("FAIL dir_done got=%b exp=11", {bus.ld_done, bus.ld_busy});
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.ld_done, bus.ld_busy} !== 2'b00) $display("FAIL dir_after_done got=%b exp=00", {bus.ld_done, bus.ld_busy});
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1 || tmo !== 0) $display("FAIL dir_done_count got=%0d tmo=%0d exp=1", done_cnt - d0, tmo);
        else n_pass++;
        do_fetch(8'd1);
        n_checks++;
        if ({bus.instr_valid, bus.instr} !== {1'b1, 12'h678}) $display("FAIL dir_fetch1 got=%b/%h exp=1/678", bus.instr_valid, bus.instr);
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.instr_valid, bus.instr} !== 13'h0) $display("FAIL dir_nofetch got=%b/%h exp=0/000", bus.instr_valid, bus.instr);
        else n_pass++;
        for (int i = 0; i < 3; i += 2) begin
            do_fetch(8'(i));
            n_checks++;
            if (bus.instr !== model[i]) $display("FAIL dir_fetch_%0d got=%h exp=%h", i, bus.instr, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random_load();
        logic [11:0] w [4];
        logic rdy_w, busy_w;
        int tmo = 0;
        int d0 = done_cnt;
        for (int i = 0; i < 4; i++) w[i] = 12'($urandom);
        start_session(8'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                // Restart attempt with a different last address plus a fetch, both mid-session.
                bus.ld_start = 1'b1; bus.ld_last = 8'd0;
                bus.fetch_en = 1'b1; bus.fetch_addr = 8'd0;
                tick();
                bus.ld_start = 1'b0; bus.fetch_en = 1'b0;
                n_checks++;
                if ({bus.instr_valid, bus.instr} !== 13'h0) $display("FAIL busy_fetch got=%b/%h exp=0/000", bus.instr_valid, bus.instr);
                else n_pass++;
            end
            send_word(w[i], 1'b1, 1'b1, tmo, rdy_w, busy_w);
            n_checks++;
            if (rdy_w !== 1'b0) $display("FAIL rnd_write_ready_%0d got=%b exp=0", i, rdy_w);
            else n_pass++;
            model[i] = w[i];
        end
        tick();
        n_checks++;
        if (bus.ld_done !== 1'b1) $display("FAIL rnd_done got=%b exp=1", bus.ld_done);
        else n_pass++;
        tick();
        n_checks++;
        if (done_cnt - d0 !== 1 || tmo !== 0 || bus.ld_busy !== 1'b0)
            $display("FAIL rnd_session_end got=%0d/%0d/%b exp=1/0/0", done_cnt - d0, tmo, bus.ld_busy);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            do_fetch(8'(i));
            n_checks++;
            if (bus.instr !== model[i]) $display("FAIL rnd_image_%0d got=%h exp=%h", i, bus.instr, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] w;
        logic rdy_w, busy_w;
        int tmo = 0;
        int d0;
        start_session(8'd4);
        for (int i = 0; i < 5; i++) begin
            w = 12'($urandom);
            send_word(w, 1'b0, 1'b1, tmo, rdy_w, busy_w);
            model[i] = w;
        end
        repeat (2) tick();
        start_session(8'd4);
        for (int i = 0; i < 3; i++) begin
            w = model[i] ^ 12'hFFF;
            send_word(w, 1'b1, 1'b1, tmo, rdy_w, busy_w);
            model[i] = w;
        end
        send_byte(8'h5A, 1'b0, tmo);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({bus.ld_ready, bus.ld_busy, bus.ld_done} !== 3'b000)
            $display("FAIL midrst_flags got=%b exp=000", {bus.ld_ready, bus.ld_busy, bus.ld_done});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            do_fetch(8'(i));
            n_checks++;
            if (bus.instr !== model[i]) $display("FAIL midrst_word_%0d got=%h exp=%h", i, bus.instr, model[i]);
            else n_pass++;
        end
        d0 = done_cnt;
        start_session(8'd1);
        for (int i = 0; i < 2; i++) begin
            w = 12'($urandom);
            send_word(w, 1'b1, 1'b0, tmo, rdy_w, busy_w);
            model[i] = w;
        end
        repeat (2) tick();
        n_checks++;
        if (done_cnt - d0 !== 1 || tmo !== 0) $display("FAIL midrst_resume got=%0d tmo=%0d exp=1", done_cnt - d0, tmo);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_fetch(8'(i));
            n_checks++;
            if (bus.instr !== model[i]) $display("FAIL resume_word_%0d got=%h exp=%h", i, bus.instr, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_fetch_with_start();
        logic [11:0] w;
        logic rdy_w, busy_w;
        int tmo = 0;
        bus.ld_start = 1'b1; bus.ld_last = 8'd0;
        bus.fetch_en = 1'b1; bus.fetch_addr = 8'd3;
        tick();
        bus.ld_start = 1'b0; bus.fetch_en = 1'b0;
        n_checks++;
        if ({bus.instr_valid, bus.instr, bus.ld_busy} !== {1'b1, model[3], 1'b1})
            $display("FAIL start_fetch got=%b/%h/%b exp=1/%h/1", bus.instr_valid, bus.instr, bus.ld_busy, model[3]);
        else n_pass++;
        w = 12'($urandom);
        send_word(w, 1'b0, 1'b1, tmo, rdy_w, busy_w);
        model[0] = w;
        tick();
        n_checks++;
        if (bus.ld_done !== 1'b1 || tmo !== 0) $display("FAIL one_word_done got=%b tmo=%0d exp=1", bus.ld_done, tmo);
        else n_pass++;
        tick();
        for (int i = 0; i < 2; i++) begin
            do_fetch(8'(i));
            n_checks++;
            if (bus.instr !== model[i]) $display("FAIL one_word_%0d got=%h exp=%h", i, bus.instr, model[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back_fetch();
        bit en;
        logic [7:0] a;
        for (int i = 0; i < 24; i++) begin
            en = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 4));
            bus.fetch_en   = en;
            bus.fetch_addr = a;
            tick();
            n_checks++;
            if ({bus.instr_valid, bus.instr} !== (en ? {1'b1, model[a]} : 13'h0))
                $display("FAIL b2b_fetch_%0d got=%b/%h exp=%b/%h", i, bus.instr_valid, bus.instr, en, en ? model[a] : 12'h0);
            else n_pass++;
        end
        bus.fetch_en = 1'b0;
        tick();
    endtask

    task automatic test_small_depth();
        logic [11:0] w [4];
        int g;
        int tmo = 0;
        int d0 = done_cnt2;
        for (int i = 0; i < 4; i++) w[i] = 12'($urandom);
        bus2.ld_start = 1'b1; bus2.ld_last = 2'd3;
        tick();
        bus2.ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                bus2.ld_valid = 1'b1;
                bus2.ld_byte  = (k == 0) ? w[i][7:0] : {4'h0, w[i][11:8]};
                g = 0;
                while (bus2.ld_ready !== 1'b1 && g < 40) begin tick(); g++; end
                if (g >= 40) tmo++;
                tick();
                bus2.ld_valid = 1'b0;
            end
        end
        repeat (6) tick();
        n_checks++;
        if (done_cnt2 - d0 !== 1 || tmo !== 0 || bus2.ld_busy !== 1'b0)
            $display("FAIL aw2_done got=%0d/%0d/%b exp=1/0/0", done_cnt2 - d0, tmo, bus2.ld_busy);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            bus2.fetch_en = 1'b1; bus2.fetch_addr = 2'(i);
            tick();
            bus2.fetch_en = 1'b0;
            n_checks++;
            if ({bus2.instr_valid, bus2.instr} !== {1'b1, w[i]})
                $display("FAIL aw2_word_%0d got=%b/%h exp=1/%h", i, bus2.instr_valid, bus2.instr, w[i]);
            else n_pass++;
        end
    endtask

    initial begin
        bus.fetch_en = 1'b0;  bus.fetch_addr = '0; bus.ld_start = 1'b0;
        bus.ld_last  = '0;    bus.ld_valid   = 1'b0; bus.ld_byte = '0;
        bus2.fetch_en = 1'b0; bus2.fetch_addr = '0; bus2.ld_start = 1'b0;
        bus2.ld_last  = '0;   bus2.ld_valid   = 1'b0; bus2.ld_byte = '0;
        test_reset();
        test_directed();
        test_random_load();
        test_reset_mid();
        test_fetch_with_start();
        test_back_to_back_fetch();
        test_small_depth();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
